// File: rtl/rr_grant_arb8.sv
// ============================================================================
//  Module      : rr_grant_arb8
//  Description : 8-way round-robin arbiter with hold-until-release, optional
//                hold-timeout preemption and a lock input that blocks it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_arb8 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic             lock,
    output logic [7:0]       grant,
    output logic [2:0]       grant_idx,
    output logic             grant_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_grant = 1'b1;

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [2:0]       r_ptr;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_hold;
    logic [7:0]       r_grant;

    logic [0:0]       w_state_nxt;
    logic [2:0]       w_ptr_nxt;
    logic [2:0]       w_idx_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [7:0]       w_grant_nxt;

    logic [7:0]       w_holder_oh;
    logic [7:0]       w_others;
    logic             w_holder_req;
    logic [2:0]       w_after;
    logic [2:0]       w_idle_win;
    logic [2:0]       w_next_win;
    logic             w_hold_sat;
    logic             w_timeout;

    // First set bit of mask scanning upward from start, wrapping 7 -> 0.
    function automatic logic [2:0] f_pick(input logic [7:0] mask,
                                          input logic [2:0] start);
        logic [2:0] v_idx;
        f_pick = start;
        for (int k = 7; k >= 0; k--) begin
            v_idx = start + 3'(k);
            if (mask[v_idx]) begin
                f_pick = v_idx;
            end
        end
    endfunction

    assign w_holder_oh  = 8'b0000_0001 << r_idx;
    assign w_others     = req & ~w_holder_oh;
    assign w_holder_req = |(req & w_holder_oh);
    assign w_after      = r_idx + 3'd1;
    assign w_idle_win   = f_pick(req, r_ptr);
    assign w_next_win   = f_pick(w_others, w_after);
    assign w_hold_sat   = &r_hold;

    // Timeout stays asserted once reached so a late competitor still preempts.
    generate
        if (MAX_HOLD == 0) begin : g_no_preempt
            assign w_timeout = 1'b0;
        end else if (MAX_HOLD == 1) begin : g_preempt_every
            assign w_timeout = 1'b1;
        end else begin : g_preempt_cnt
            localparam logic [CNT_W-1:0] c_hold_lim = CNT_W'(MAX_HOLD - 1);
            assign w_timeout = (r_hold >= c_hold_lim);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= 3'd0;
            r_idx   <= 3'd0;
            r_hold  <= '0;
            r_grant <= 8'h00;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        case (r_state)
            c_idle: begin
                if (|req) begin
                    w_state_nxt = c_grant;
                    w_idx_nxt   = w_idle_win;
                    w_hold_nxt  = '0;
                end
            end
            c_grant: begin
                if (!w_holder_req) begin
                    w_ptr_nxt = w_after;
                    if (|w_others) begin
                        w_idx_nxt  = w_next_win;
                        w_hold_nxt = '0;
                    end else begin
                        w_state_nxt = c_idle;
                        w_idx_nxt   = 3'd0;
                        w_hold_nxt  = '0;
                    end
                end else if (w_timeout && !lock && (|w_others)) begin
                    w_ptr_nxt  = w_after;
                    w_idx_nxt  = w_next_win;
                    w_hold_nxt = '0;
                end else if (!w_hold_sat) begin
                    w_hold_nxt = r_hold + c_one;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_idx_nxt   = 3'd0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Decode ahead of the register so grant leaves a flop, never glitches.
    always_comb begin
        w_grant_nxt = 8'h00;
        if (w_state_nxt == c_grant) begin
            w_grant_nxt = 8'b0000_0001 << w_idx_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = (r_state == c_grant);
    assign hold_cnt    = r_hold;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_arb8.sv
// ============================================================================
//  Module      : tb_rr_grant_arb8
//  Description : Directed, scoreboard-checked bench for rr_grant_arb8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_grant_arb8;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] req    = 8'h00;
    logic       lock   = 1'b0;
    logic [7:0] req_b  = 8'h00;
    logic       lock_b = 1'b0;

    logic [7:0] grant,       grant_b;
    logic [2:0] grant_idx,   grant_idx_b;
    logic       grant_valid, grant_valid_b;
    logic [7:0] hold_cnt,    hold_cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_grant_arb8 #(.MAX_HOLD(4), .CNT_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .hold_cnt    (hold_cnt)
    );

    rr_grant_arb8 #(.MAX_HOLD(0), .CNT_W(8)) u_dut_nohold (
        .clk         (clk),
        .rst         (rst),
        .req         (req_b),
        .lock        (lock_b),
        .grant       (grant_b),
        .grant_idx   (grant_idx_b),
        .grant_valid (grant_valid_b),
        .hold_cnt    (hold_cnt_b)
    );

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic [7:0] hold;
    } exp_t;

    exp_t sb[$];

    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;
    logic [7:0] m_hold;

    function automatic logic [2:0] scan(input logic [7:0] m, input logic [2:0] s);
        logic [2:0] p;
        p = s;
        for (int k = 0; k < 8; k++) begin
            if (m[p]) return p;
            p = p + 3'd1;
        end
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 3'd0;
        m_ptr   = 3'd0;
        m_hold  = 8'd0;
    endtask

    // Reference behaviour of one rising edge for the MAX_HOLD=4 instance.
    task automatic model_edge(input logic [7:0] r, input logic l);
        logic [7:0] o;
        if (!m_valid) begin
            if (r != 8'h00) begin
                m_valid = 1'b1;
                m_idx   = scan(r, m_ptr);
                m_hold  = 8'd0;
            end
        end else begin
            o        = r;
            o[m_idx] = 1'b0;
            if (!r[m_idx]) begin
                m_ptr = m_idx + 3'd1;
                if (o != 8'h00) begin
                    m_idx  = scan(o, m_ptr);
                    m_hold = 8'd0;
                end else begin
                    m_valid = 1'b0;
                    m_idx   = 3'd0;
                    m_hold  = 8'd0;
                end
            end else if (m_hold >= 8'd3 && !l && o != 8'h00) begin
                m_ptr  = m_idx + 3'd1;
                m_idx  = scan(o, m_ptr);
                m_hold = 8'd0;
            end else if (m_hold != 8'hFF) begin
                m_hold = m_hold + 8'd1;
            end
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.grant = m_valid ? (8'h01 << m_idx) : 8'h00;
        e.idx   = m_idx;
        e.valid = m_valid;
        e.hold  = m_hold;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".grant"},  32'(grant),            32'(e.grant));
        chk({tag, ".idx"},    32'(grant_idx),        32'(e.idx));
        chk({tag, ".valid"},  32'(grant_valid),      32'(e.valid));
        chk({tag, ".hold"},   32'(hold_cnt),         32'(e.hold));
        chk({tag, ".onehot"}, 32'($onehot0(grant)),  32'd1);
    endtask

    task automatic cycle(input logic [7:0] r, input logic l, input string tag);
        @(negedge clk);
        req  = r;
        lock = l;
        model_edge(r, l);
        push_model();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #2;
        push_model();
        pop_check("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Lone requester keeps the grant past the timeout.
        for (int i = 0; i < 10; i++) cycle(8'h20, 1'b0, "single");
        chk("single.hold_end", 32'(hold_cnt), 32'd9);
        chk("single.grant_end", 32'(grant), 32'h20);
        cycle(8'h00, 1'b0, "single_drop");
        chk("single_drop.grant", 32'(grant), 32'h00);

        // Back-to-back release, then wrap from 7 to 0.
        cycle(8'h04, 1'b0, "b2b_start");
        chk("b2b_start.idx", 32'(grant_idx), 32'd2);
        cycle(8'h84, 1'b0, "b2b_keep");
        cycle(8'h80, 1'b0, "b2b_rel");
        chk("b2b_rel.idx", 32'(grant_idx), 32'd7);
        chk("b2b_rel.grant", 32'(grant), 32'h80);
        cycle(8'h01, 1'b0, "b2b_wrap");
        chk("b2b_wrap.idx", 32'(grant_idx), 32'd0);
        cycle(8'h00, 1'b0, "b2b_idle");

        // Asynchronous reset in the middle of a grant.
        cycle(8'h08, 1'b0, "rst_pre");
        chk("rst_pre.grant", 32'(grant), 32'h08);
        #2;
        rst = 1'b1;
        req = 8'h00;
        #1;
        model_reset();
        push_model();
        pop_check("rst_async");
        @(negedge clk);
        rst = 1'b0;
        cycle(8'h01, 1'b0, "rst_post");
        chk("rst_post.grant", 32'(grant), 32'h01);
        cycle(8'h00, 1'b0, "rst_rel");

        // Clear the pointer before the fairness sweep.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        push_model();
        pop_check("rst_pulse");

        // Everyone requesting: each index owns 4 cycles in order.
        for (int i = 0; i < 34; i++) begin
            cycle(8'hFF, 1'b0, "fair");
            chk("fair.seq", 32'(grant_idx), 32'((i / 4) % 8));
        end
        cycle(8'h00, 1'b0, "fair_end");

        // Lock holds requester 3 until it drops.
        for (int i = 0; i < 7; i++) cycle(8'h18, 1'b1, "lock_hold");
        chk("lock_hold.idx", 32'(grant_idx), 32'd3);
        chk("lock_hold.hold", 32'(hold_cnt), 32'd6);
        cycle(8'h18, 1'b0, "lock_drop");
        chk("lock_drop.idx", 32'(grant_idx), 32'd4);
        cycle(8'h00, 1'b0, "lock_end");

        // Preemption disabled instance.
        @(negedge clk);
        req_b = 8'h03;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("nohold.idx", 32'(grant_idx_b), 32'd0);
            chk("nohold.valid", 32'(grant_valid_b), 32'd1);
        end
        chk("nohold.hold", 32'(hold_cnt_b), 32'd19);
        @(negedge clk);
        req_b = 8'h02;
        @(posedge clk);
        #1;
        chk("nohold_rel.idx", 32'(grant_idx_b), 32'd1);
        chk("nohold_rel.grant", 32'(grant_b), 32'h02);
        chk("nohold_rel.hold", 32'(hold_cnt_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_grant_arb8.md
Name: rr_grant_arb8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Issues the winner as a 3-bit index plus a one-hot 8-bit grant, decoded 3-to-8 from the index and gated by valid.
- Sits in front of any shared resource in the design that is selected through a 3-to-8 decode.
- Supports hold-until-release, an optional hold timeout for preemption, and a lock input that suppresses preemption.

Parameters:
- MAX_HOLD, 4: maximum grant cycles before preemption when other requests are pending. 0 disables preemption. Legal range 0-255.
- CNT_W, 8: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req  input  8  request per requester; bit i = requester i
- lock  input  1  current holder forbids preemption while high
- grant  output  8  one-hot grant; all zeros when idle
- grant_idx  output  3  index of current holder; 0 when idle
- grant_valid  output  1  high while a grant is active
- hold_cnt  output  CNT_W  cycles the current grant has been held, minus 1

Behaviour:
- Reset (asynchronous, immediate): grant=8'h00, grant_idx=0, grant_valid=0, hold_cnt=0, priority pointer ptr=0, state=IDLE. Reset mid-grant drops the grant at once with no release cycle.
- All outputs are registered. grant equals decode(grant_idx) when grant_valid=1, otherwise 8'h00. grant never has more than one bit set.
- Winner search: first i with req[i]=1, scanning ptr, ptr+1, ... ptr+7, modulo 8 (wraps 7 to 0).
- IDLE:
  - If req!=0 at edge N, then after edge N: grant_valid=1, grant_idx=winner, hold_cnt=0, state=GRANT. Request-to-grant latency is 1 cycle.
  - If req==0, remain in IDLE.
- GRANT, holder g. Events are evaluated at each edge in priority order:
  1. Release. req[g]=0: ptr<=g+1 mod 8. Others are req with bit g masked. If others!=0, grant the winner searched from g+1 at the same edge (no bubble) and set hold_cnt=0. Otherwise go to IDLE: grant_valid=0, grant_idx=0, hold_cnt=0.
  2. Preempt. req[g]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, lock=0, and others!=0: ptr<=g+1, grant the next winner from g+1, hold_cnt=0.
  3. Otherwise keep holder g. hold_cnt increments, saturating at 2^CNT_W-1. When a timeout is reached with no other requester, g keeps the grant and hold_cnt keeps counting; preemption fires at the first later edge where others!=0 and lock=0.
- lock is sampled only in GRANT. Its value in IDLE is ignored. lock does not prevent release.
- Simultaneous release by g and a new request by g at the same edge: req[g]=0 at that edge means release. A later reassertion re-arbitrates normally; g has lowest priority until the pointer passes it.
- Fairness: with all 8 requesting continuously and MAX_HOLD=4, each index is granted for 4 cycles in order 0..7, then 0 again.
- ptr updates only on release or preemption, never in IDLE.

Test Plan:
- Reset: assert rst mid-grant (grant=8'h08) -> grant=8'h00, grant_valid=0, grant_idx=0 immediately, before the next clock edge. After release, req=8'h01 -> grant=8'h01 one cycle later.
- Single requester: req=8'h20 held 10 cycles, MAX_HOLD=4 -> grant=8'h20 throughout, hold_cnt runs 0..9. Drop req -> next cycle grant=8'h00, grant_valid=0.
- Back-to-back release: holder 2, req=8'h84, drop bit 2 -> next cycle grant=8'h80, grant_idx=7, no idle cycle. Drop bit 7 with req=8'h01 -> grant_idx=0 (wrap).
- Preemption: req=8'hFF held, MAX_HOLD=4 -> grant_idx sequence 0,0,0,0,1,1,1,1,... up to 7, then 0. Each index held exactly 4 cycles.
- Lock: holder 3, req=8'h18, lock=1 -> holder 3 kept past hold_cnt=3. Drop lock at hold_cnt=6 -> next cycle grant_idx=4.
- MAX_HOLD=0: req=8'h03 held 20 cycles -> grant_idx stays 0 with no preemption. Drop bit 0 -> grant_idx=1.
